// File: rtl/bitserial_pkg.sv
// Shared types and helpers for the bit-serial operand streamer.
//   state_t    : streamer FSM states
//   pair_tag_t : per-pair dot-product framing flags stored alongside operands
//   clog2      : ceiling log2 usable in parameter/port width expressions
package bitserial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_SHIFT     = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic first;   // clear the accumulator when this pair launches
      logic last;    // report dot_done when this pair's multiply completes
   } pair_tag_t;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < value) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/operand_fifo.sv
// Synchronous FIFO holding packed operand-pair entries.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data this cycle; caller pushes only when
//                count < DEPTH, or when full together with pop
//   pop        : drop the head entry this cycle; caller pops only when count > 0
//   pop_data   : current head entry (combinational read of storage)
//   count      : occupied entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module operand_fifo
   import bitserial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic [clog2(DEPTH):0]  count
);

   localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         // simultaneous push and pop leaves the occupancy unchanged
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   // When full with push+pop, the write lands on the slot being read out,
   // which is safe because the head is consumed at the same edge.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/bitserial_operand_streamer.sv
// Initiator side of the bit-serial MAC operand interface.
// Buffers (multiplicand, multiplier) pairs, then launches one MAC operation
// per pair: multiplicand in parallel, multiplier LSB-first one bit per cycle,
// then waits for mac_done (bounded by DONE_TIMEOUT).
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid/in_ready                  upstream handshake
//   in_multiplicand/in_multiplier      operand pair
//   in_first/in_last                   dot-product framing flags
//   mac_start/mac_clear_acc            launch pulse and accumulator clear
//   mac_multiplicand/mac_multiplier    operands held from launch to next launch
//   mac_serial_bit                     serial multiplier bit
//   mac_done                           MAC completion
//   dot_done                           pulse after completion of an in_last pair
//   busy, fifo_count, timeout_err      status
//
// Handshake: a pair transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the registered FIFO count (count < FIFO_DEPTH),
// never on this cycle's pop, so there is no combinational ready path.
// in_valid may be held high while in_ready is low; data must stay stable.
module bitserial_operand_streamer
   import bitserial_pkg::*;
#(
   parameter int MULTIPLICAND_WIDTH = 16,
   parameter int MULTIPLIER_WIDTH   = 16,
   parameter int FIFO_DEPTH         = 4,
   parameter int DONE_TIMEOUT       = 64
)
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [MULTIPLICAND_WIDTH-1:0]  in_multiplicand,
   input  logic [MULTIPLIER_WIDTH-1:0]    in_multiplier,
   input  logic                           in_first,
   input  logic                           in_last,
   output logic                           mac_start,
   output logic                           mac_clear_acc,
   output logic [MULTIPLICAND_WIDTH-1:0]  mac_multiplicand,
   output logic [MULTIPLIER_WIDTH-1:0]    mac_multiplier,
   output logic                           mac_serial_bit,
   input  logic                           mac_done,
   output logic                           dot_done,
   output logic                           busy,
   output logic [clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                           timeout_err
);

   localparam int W1        = MULTIPLICAND_WIDTH;
   localparam int W2        = MULTIPLIER_WIDTH;
   localparam int ENTRY_W   = W1 + W2 + 2;
   localparam int CNT_W     = clog2(FIFO_DEPTH) + 1;
   localparam int BIT_CNT_W = clog2(W2) + 1;
   localparam int TMO_W     = clog2(DONE_TIMEOUT) + 1;

   localparam logic [CNT_W-1:0]     FIFO_FULL    = CNT_W'(FIFO_DEPTH);
   localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(W2);
   localparam logic [TMO_W-1:0]     TMO_LAST     = TMO_W'(DONE_TIMEOUT - 1);

   // ---------------- operand buffer ----------------
   pair_tag_t          in_tag;
   pair_tag_t          head_tag;
   logic [ENTRY_W-1:0] fifo_in;
   logic [ENTRY_W-1:0] fifo_head;
   logic [W1-1:0]      head_mcand;
   logic [W2-1:0]      head_mplier;
   logic               push;
   logic               pop;

   state_t             state;

   assign in_tag.first = in_first;
   assign in_tag.last  = in_last;
   assign fifo_in      = {in_multiplicand, in_multiplier, in_tag};

   assign head_mcand   = fifo_head[ENTRY_W-1 -: W1];
   assign head_mplier  = fifo_head[2 +: W2];
   assign head_tag     = pair_tag_t'(fifo_head[1:0]);

   assign in_ready = (fifo_count < FIFO_FULL);
   assign push     = in_valid && in_ready;
   // Pairs leave the buffer only on the IDLE -> LAUNCH transition.
   assign pop      = (state == ST_IDLE) && (fifo_count != '0);

   operand_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (fifo_in),
      .pop       (pop),
      .pop_data  (fifo_head),
      .count     (fifo_count)
   );

   // ---------------- launch / shift / wait FSM ----------------
   logic [W2-1:0]        shift_reg;   // multiplier bits not yet driven, LSB next
   logic [BIT_CNT_W-1:0] bit_cnt;     // multiplier bits already driven
   logic [TMO_W-1:0]     tmo_cnt;     // cycles spent in WAIT_DONE
   logic                 held_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         shift_reg        <= '0;
         bit_cnt          <= '0;
         tmo_cnt          <= '0;
         held_last        <= 1'b0;
         mac_start        <= 1'b0;
         mac_clear_acc    <= 1'b0;
         mac_multiplicand <= '0;
         mac_multiplier   <= '0;
         mac_serial_bit   <= 1'b0;
         dot_done         <= 1'b0;
         timeout_err      <= 1'b0;
      end else begin
         mac_start     <= 1'b0;
         mac_clear_acc <= 1'b0;
         dot_done      <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state            <= ST_LAUNCH;
                  mac_start        <= 1'b1;
                  mac_clear_acc    <= head_tag.first;
                  held_last        <= head_tag.last;
                  mac_multiplicand <= head_mcand;
                  mac_multiplier   <= head_mplier;
                  mac_serial_bit   <= head_mplier[0];
                  shift_reg        <= head_mplier >> 1;
                  bit_cnt          <= BIT_CNT_W'(1);
               end
            end

            // LAUNCH drives bit 0 (loaded above); every later cycle drives
            // the next bit until all W2 bits are out. With W2 == 1 the
            // count is already complete in LAUNCH, so SHIFT is skipped.
            // mac_done arriving here is a protocol violation and is ignored.
            ST_LAUNCH, ST_SHIFT: begin
               if (bit_cnt == BIT_CNT_LAST) begin
                  state          <= ST_WAIT_DONE;
                  mac_serial_bit <= 1'b0;
                  tmo_cnt        <= '0;
               end else begin
                  state          <= ST_SHIFT;
                  mac_serial_bit <= shift_reg[0];
                  shift_reg      <= shift_reg >> 1;
                  bit_cnt        <= bit_cnt + 1'b1;
               end
            end

            ST_WAIT_DONE: begin
               if (mac_done) begin
                  state    <= ST_IDLE;
                  dot_done <= held_last;
               end else if (tmo_cnt == TMO_LAST) begin
                  // give up on this pair; the error stays set until reset
                  state       <= ST_IDLE;
                  timeout_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE) || (fifo_count != '0);

endmodule
